// File: rtl/clk_period_meter.sv
// Measures period and high time of an asynchronous slow clock/strobe in clk cycles,
// with lock and sticky timeout flags. Define CLK_PERIOD_METER_DEGLITCH_EN for a 2-cycle input filter.
//
// state | meaning
// IDLE  | disabled; counter held at 0
// ARM   | waiting for the first rise; counter runs for timeout only
// RUN   | measuring between consecutive rises
module clk_period_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000,
  parameter int LOCK_N  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [3:0]       LOCK_C    = 4'(LOCK_N);

  state_t           state_q, state_d;
  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hlatch_q, hlatch_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic [3:0]       lock_cnt_q, lock_cnt_d;
  logic             have_prev_q, have_prev_d;

  logic             lvl;
  logic             rise;
  logic             fall;
  logic             tmo_hit;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       lock_next;

`ifdef CLK_PERIOD_METER_DEGLITCH_EN
  logic s2h_q, s2h_d;
  logic filt_q, filt_d;

  // Filtered level follows s2 only once s2 has shown the same value on two consecutive cycles.
  always_comb begin
    s2h_d  = s2_q;
    filt_d = filt_q;
    if (s2_q == s2h_q) begin
      filt_d = s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2h_q  <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      s2h_q  <= s2h_d;
      filt_q <= filt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif

  assign rise    = lvl & ~d_q;
  assign fall    = ~lvl & d_q;
  assign tmo_hit = (cnt_q >= TIMEOUT_C) && !rise;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

  // Run length of identical periods; the first measurement after arming starts a new run.
  always_comb begin
    lock_next = 4'd1;
    if (have_prev_q && (cnt_q == period_q)) begin
      lock_next = (lock_cnt_q == LOCK_C) ? lock_cnt_q : lock_cnt_q + 4'd1;
    end
  end

  always_comb begin
    s1_d        = sig_in;
    s2_d        = s1_q;
    d_d         = lvl;
    state_d     = state_q;
    cnt_d       = cnt_q;
    hlatch_d    = hlatch_q;
    period_d    = period_q;
    high_d      = high_q;
    valid_d     = 1'b0;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    lock_cnt_d  = lock_cnt_q;
    have_prev_d = have_prev_q;

    if (!en) begin
      state_d     = IDLE;
      cnt_d       = '0;
      locked_d    = 1'b0;
      lock_cnt_d  = 4'd0;
      have_prev_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d       = '0;
          lock_cnt_d  = 4'd0;
          have_prev_d = 1'b0;
          state_d     = ARM;
        end
        ARM: begin
          if (rise) begin
            cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
            state_d = RUN;
          end else if (tmo_hit) begin
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            lock_cnt_d  = 4'd0;
            have_prev_d = 1'b0;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RUN: begin
          cnt_d = cnt_inc;
          if (fall) begin
            hlatch_d = cnt_q;
          end
          // A rise on the timeout threshold cycle still counts as a measurement.
          if (rise) begin
            period_d    = cnt_q;
            high_d      = hlatch_q;
            valid_d     = 1'b1;
            timeout_d   = 1'b0;
            cnt_d       = {{(CNT_W-1){1'b0}}, 1'b1};
            lock_cnt_d  = lock_next;
            locked_d    = (lock_next == LOCK_C);
            have_prev_d = 1'b1;
          end else if (tmo_hit) begin
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            lock_cnt_d  = 4'd0;
            have_prev_d = 1'b0;
            cnt_d       = '0;
            state_d     = ARM;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      d_q         <= 1'b0;
      cnt_q       <= '0;
      hlatch_q    <= '0;
      period_q    <= '0;
      high_q      <= '0;
      valid_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      lock_cnt_q  <= 4'd0;
      have_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      d_q         <= d_d;
      cnt_q       <= cnt_d;
      hlatch_q    <= hlatch_d;
      period_q    <= period_d;
      high_q      <= high_d;
      valid_q     <= valid_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      lock_cnt_q  <= lock_cnt_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

endmodule
